// File: rtl/gray_converter.sv
// Serial RGB-to-gray converter: collects R, G, B bytes, computes one gray value per pixel.
// Optional build macro GS_ROUND_EN adds round-half-up to the BT.601 and average modes.
module gray_converter #(
  parameter int DW    = 8,
  parameter int IMG_W = 2,
  parameter int IMG_H = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          gs_enable,
  input  logic [1:0]    mode,
  input  logic          din_valid,
  input  logic [DW-1:0] din,
  output logic          pause,
  output logic [DW-1:0] dout,
  output logic          dout_valid,
  input  logic          dout_ready,
  output logic          busy,
  output logic          gs_done
);

  localparam int NPIX = IMG_W * IMG_H;
  localparam int PW   = (NPIX > 1) ? $clog2(NPIX) : 1;
  localparam int IW   = DW + 10;

  localparam logic [PW-1:0] LAST_PIX = PW'(NPIX - 1);
  localparam logic [IW-1:0] K_R      = IW'(77);
  localparam logic [IW-1:0] K_G      = IW'(150);
  localparam logic [IW-1:0] K_B      = IW'(29);
  localparam logic [IW-1:0] K_AVG    = IW'(85);
  localparam logic [IW-1:0] MAXV     = {{10{1'b0}}, {DW{1'b1}}};
`ifdef GS_ROUND_EN
  localparam logic [IW-1:0] RND      = IW'(128);
`else
  localparam logic [IW-1:0] RND      = IW'(0);
`endif

  typedef enum logic [2:0] {IDLE, FILL, CALC, OUT, DONE} state_t;

  state_t        state;
  logic [1:0]    mode_reg;
  logic [1:0]    ch_cnt;
  logic [PW-1:0] pix_cnt;
  logic [DW-1:0] r_reg, g_reg, b_reg;

  logic [IW-1:0] r_w, g_w, b_w, sum;
  logic [DW-1:0] result;

  always_comb begin
    r_w = IW'(r_reg);
    g_w = IW'(g_reg);
    b_w = IW'(b_reg);
    sum = '0;
    case (mode_reg)
      2'd1:    sum = (r_w * K_R + g_w * K_G + b_w * K_B + RND) >> 8;
      2'd2:    sum = ((r_w + g_w + b_w) * K_AVG + RND) >> 8;
      // mode 3 falls back to the shift approximation
      default: sum = (r_w >> 2) + (r_w >> 5) + (g_w >> 1) + (g_w >> 4)
                   + (b_w >> 4) + (b_w >> 5);
    endcase
    result = (sum > MAXV) ? {DW{1'b1}} : sum[DW-1:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      mode_reg   <= 2'd0;
      ch_cnt     <= 2'd0;
      pix_cnt    <= '0;
      r_reg      <= '0;
      g_reg      <= '0;
      b_reg      <= '0;
      pause      <= 1'b0;
      dout       <= '0;
      dout_valid <= 1'b0;
      busy       <= 1'b0;
      gs_done    <= 1'b0;
    end else begin
      gs_done <= 1'b0;
      // losing the enable mid-frame discards everything and returns to IDLE
      if (state != IDLE && !gs_enable) begin
        state      <= IDLE;
        ch_cnt     <= 2'd0;
        pix_cnt    <= '0;
        pause      <= 1'b0;
        dout       <= '0;
        dout_valid <= 1'b0;
        busy       <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (gs_enable) begin
              mode_reg <= mode;
              ch_cnt   <= 2'd0;
              pix_cnt  <= '0;
              busy     <= 1'b1;
              state    <= FILL;
            end
          end
          FILL: begin
            if (din_valid) begin
              case (ch_cnt)
                2'd0:    r_reg <= din;
                2'd1:    g_reg <= din;
                default: b_reg <= din;
              endcase
              if (ch_cnt == 2'd2) begin
                ch_cnt <= 2'd0;
                pause  <= 1'b1;
                state  <= CALC;
              end else begin
                ch_cnt <= ch_cnt + 2'd1;
              end
            end
          end
          CALC: begin
            dout       <= result;
            dout_valid <= 1'b1;
            state      <= OUT;
          end
          OUT: begin
            if (dout_ready) begin
              dout       <= '0;
              dout_valid <= 1'b0;
              pix_cnt    <= pix_cnt + PW'(1);
              if (pix_cnt == LAST_PIX) begin
                gs_done <= 1'b1;
                state   <= DONE;
              end else begin
                pause <= 1'b0;
                state <= FILL;
              end
            end
          end
          DONE: begin
            pix_cnt <= '0;
            pause   <= 1'b0;
            busy    <= 1'b0;
            state   <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_gray_converter.sv
// Directed bench for gray_converter: frames in every mode, stalls, gaps, abort and reset.
module tb_gray_converter;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       gs_enable;
  logic [1:0] mode;
  logic       din_valid;
  logic [7:0] din;
  logic       pause;
  logic [7:0] dout;
  logic       dout_valid;
  logic       dout_ready;
  logic       busy;
  logic       gs_done;

  int checks = 0;
  int errors = 0;

`ifdef GS_ROUND_EN
  localparam logic [7:0] RB = 8'd1;
`else
  localparam logic [7:0] RB = 8'd0;
`endif

  gray_converter #(.DW(8), .IMG_W(2), .IMG_H(2)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .gs_enable  (gs_enable),
    .mode       (mode),
    .din_valid  (din_valid),
    .din        (din),
    .pause      (pause),
    .dout       (dout),
    .dout_valid (dout_valid),
    .dout_ready (dout_ready),
    .busy       (busy),
    .gs_done    (gs_done)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] v);
    din       = v;
    din_valid = 1'b1;
    tick();
    din_valid = 1'b0;
  endtask

  task automatic start_frame(input logic [1:0] m);
    mode      = m;
    gs_enable = 1'b1;
    tick();
    chk("start_busy", busy, 1);
    chk("start_pause", pause, 0);
  endtask

  // One pixel: optional idle gap after R, optional dout_ready stall in OUT.
  task automatic pixel(input string tag, input logic [7:0] r, input logic [7:0] g,
                       input logic [7:0] b, input logic [7:0] exp, input bit last,
                       input int stall, input int gap);
    $display("pixel %s: R=%0d G=%0d B=%0d expect=%0d stall=%0d gap=%0d",
             tag, r, g, b, exp, stall, gap);
    send_byte(r);
    for (int i = 0; i < gap; i++) begin
      tick();
      chk({tag, "_gap_pause"}, pause, 0);
      chk({tag, "_gap_valid"}, dout_valid, 0);
    end
    send_byte(g);
    dout_ready = (stall == 0);
    send_byte(b);
    chk({tag, "_calc_valid"}, dout_valid, 0);
    chk({tag, "_calc_pause"}, pause, 1);
    tick();
    chk({tag, "_out_valid"}, dout_valid, 1);
    chk({tag, "_out_dout"}, dout, exp);
    for (int i = 0; i < stall; i++) begin
      din       = 8'hA5;
      din_valid = 1'b1;
      tick();
      chk({tag, "_stall_dout"}, dout, exp);
      chk({tag, "_stall_valid"}, dout_valid, 1);
      chk({tag, "_stall_pause"}, pause, 1);
    end
    din_valid  = 1'b0;
    dout_ready = 1'b1;
    tick();
    chk({tag, "_post_valid"}, dout_valid, 0);
    chk({tag, "_post_dout"}, dout, 0);
    chk({tag, "_post_done"}, gs_done, last);
    chk({tag, "_post_pause"}, pause, last);
  endtask

  task automatic end_frame(input string tag);
    gs_enable = 1'b0;
    tick();
    chk({tag, "_end_done"}, gs_done, 0);
    chk({tag, "_end_busy"}, busy, 0);
  endtask

  initial begin
    rst_n      = 1'b0;
    gs_enable  = 1'b0;
    mode       = 2'd0;
    din_valid  = 1'b0;
    din        = 8'd0;
    dout_ready = 1'b1;
    #1;
    chk("rst_dout", dout, 0);
    chk("rst_valid", dout_valid, 0);
    chk("rst_pause", pause, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", gs_done, 0);
    tick();
    rst_n = 1'b1;
    tick();

    // Mode 0 frame with a stall on one pixel and a gap inside another
    start_frame(2'd0);
    pixel("m0_p0", 8'd100, 8'd50, 8'd200, 8'd74, 1'b0, 0, 0);
    pixel("m0_p1", 8'd255, 8'd255, 8'd255, 8'd234, 1'b0, 5, 0);
    pixel("m0_p2", 8'd10, 8'd20, 8'd30, 8'd14, 1'b0, 0, 3);
    pixel("m0_p3", 8'd0, 8'd0, 8'd0, 8'd0, 1'b1, 0, 0);
    // back-to-back: enable stays high, new frame latches mode 3
    mode = 2'd3;
    tick();
    chk("b2b_idle_busy", busy, 0);
    chk("b2b_idle_done", gs_done, 0);
    tick();
    chk("b2b_fill_busy", busy, 1);

    // Mode 3 behaves as mode 0; abort after 5 bytes
    pixel("m3_p0", 8'd100, 8'd50, 8'd200, 8'd74, 1'b0, 0, 0);
    send_byte(8'd1);
    send_byte(8'd2);
    gs_enable = 1'b0;
    tick();
    $display("abort after 5 bytes");
    chk("abort_busy", busy, 0);
    chk("abort_pause", pause, 0);
    chk("abort_done", gs_done, 0);
    tick();
    chk("abort_done2", gs_done, 0);

    // Mode 1 frame; mode input changes mid-frame and must be ignored
    start_frame(2'd1);
    mode = 2'd2;
    pixel("m1_p0", 8'd255, 8'd255, 8'd255, 8'd255, 1'b0, 0, 0);
    pixel("m1_p1", 8'd100, 8'd50, 8'd200, 8'd82, 1'b0, 0, 0);
    pixel("m1_p2", 8'd0, 8'd0, 8'd5, RB, 1'b0, 0, 0);
    pixel("m1_p3", 8'd0, 8'd255, 8'd0, 8'd149, 1'b1, 0, 0);
    end_frame("m1");

    // Mode 2 frame
    start_frame(2'd2);
    pixel("m2_p0", 8'd100, 8'd50, 8'd200, 8'd116, 1'b0, 0, 0);
    pixel("m2_p1", 8'd255, 8'd255, 8'd255, 8'd254, 1'b0, 0, 0);
    pixel("m2_p2", 8'd3, 8'd0, 8'd0, RB, 1'b0, 0, 0);
    pixel("m2_p3", 8'd0, 8'd0, 8'd0, 8'd0, 1'b1, 0, 0);
    end_frame("m2");

    // Reset asserted while a result is held in OUT
    start_frame(2'd0);
    dout_ready = 1'b0;
    send_byte(8'd10);
    send_byte(8'd20);
    send_byte(8'd30);
    tick();
    chk("pre_rst_valid", dout_valid, 1);
    rst_n     = 1'b0;
    gs_enable = 1'b0;
    #1;
    $display("reset during OUT");
    chk("mid_rst_dout", dout, 0);
    chk("mid_rst_valid", dout_valid, 0);
    chk("mid_rst_pause", pause, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_done", gs_done, 0);
    tick();
    rst_n      = 1'b1;
    dout_ready = 1'b1;
    tick();

    start_frame(2'd1);
    pixel("r1_p0", 8'd100, 8'd50, 8'd200, 8'd82, 1'b0, 0, 0);
    pixel("r1_p1", 8'd255, 8'd255, 8'd255, 8'd255, 1'b0, 0, 0);
    pixel("r1_p2", 8'd0, 8'd255, 8'd0, 8'd149, 1'b0, 0, 0);
    pixel("r1_p3", 8'd0, 8'd0, 8'd0, 8'd0, 1'b1, 0, 0);
    end_frame("r1");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
